local_port_ingress: RTL and testbench

- Router-side ingress unit for the leaf router's local port; sits directly downstream of the processing element's outbound flit path.
- Accepts flits from the PE under credit flow control and buffers them in a FIFO.
- Forwards buffered flits one per cycle toward the router switch, gated by a credit counter that tracks free downstream buffer slots.
- Returns one credit pulse to the PE for every flit that leaves the buffer.

---
 rtl/local_port_ingress.sv | 100 ++++++++++
 tb/tb_local_port_ingress.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_port_ingress.sv
// rtl/local_port_ingress.sv - local-port ingress FIFO with credit-gated forwarding to the switch
module local_port_ingress #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 4,
  parameter int DS_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_data_valid,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic                               upstream_credit,
  output logic                               out_data_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  input  logic                               downstream_credit,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     occupancy,
  output logic                               overflow_err,
  output logic                               credit_err
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int CW = $clog2(DS_DEPTH + 1);
  localparam logic [OW-1:0] FULL_LVL   = OW'(BUF_DEPTH);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DS_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [OW-1:0]         count;
  logic [CW-1:0]         credits;
  logic                  full;
  logic                  empty;
  logic                  do_write;
  logic                  do_send;

  // Full/empty and the write/send decisions, all from pre-edge registered state
  always_comb begin
    full     = (count == FULL_LVL);
    empty    = (count == '0);
    do_write = in_data_valid && !full;
    do_send  = !empty && (credits != '0);
  end

  assign occupancy = count;

  // Flit storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (rst && do_write) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, fill level, downstream credit counter, registered outputs and sticky errors
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      credits         <= CREDIT_MAX;
      out_data_valid  <= 1'b0;
      out_data        <= '0;
      upstream_credit <= 1'b0;
      overflow_err    <= 1'b0;
      credit_err      <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      // A flit arriving on a full buffer is dropped even if a send frees a slot this edge
      if (in_data_valid && full) begin
        overflow_err <= 1'b1;
      end

      out_data_valid  <= do_send;
      upstream_credit <= do_send;
      if (do_send) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end

      case ({do_write, do_send})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase

      // A send and a returned credit in the same cycle cancel out
      if (do_send && !downstream_credit) begin
        credits <= credits - CW'(1);
      end else if (!do_send && downstream_credit) begin
        if (credits == CREDIT_MAX) begin
          credit_err <= 1'b1;
        end else begin
          credits <= credits + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_local_port_ingress.sv
// tb/tb_local_port_ingress.sv - directed self-checking bench for local_port_ingress
module tb_local_port_ingress;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          in_data_valid;
  logic [DW-1:0] in_data;
  logic          upstream_credit;
  logic          out_data_valid;
  logic [DW-1:0] out_data;
  logic          downstream_credit;
  logic [2:0]    occupancy;
  logic          overflow_err;
  logic          credit_err;

  int n_pass;
  int n_total;
  int ucnt;
  logic [DW-1:0] got [$];

  local_port_ingress #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .DS_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_data_valid     (in_data_valid),
    .in_data           (in_data),
    .upstream_credit   (upstream_credit),
    .out_data_valid    (out_data_valid),
    .out_data          (out_data),
    .downstream_credit (downstream_credit),
    .occupancy         (occupancy),
    .overflow_err      (overflow_err),
    .credit_err        (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every delivered flit and every credit pulse returned to the PE
  always @(negedge clk) begin
    if (out_data_valid) got.push_back(out_data);
    if (upstream_credit) ucnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_data_valid = 1'b0;
    in_data = '0;
    downstream_credit = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    got.delete();
    ucnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_data_valid = 1'b0;
    in_data = '0;
    downstream_credit = 1'b0;
    cyc();
    cyc();
    n_total++; if (occupancy !== 3'd0) $display("FAIL reset_occ got=%0d exp=0", occupancy); else n_pass++;
    n_total++; if (out_data_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_data_valid); else n_pass++;
    n_total++; if (out_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", out_data); else n_pass++;
    n_total++; if (upstream_credit !== 1'b0) $display("FAIL reset_ucred got=%b exp=0", upstream_credit); else n_pass++;
    n_total++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow_err); else n_pass++;
    n_total++; if (credit_err !== 1'b0) $display("FAIL reset_cerr got=%b exp=0", credit_err); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_single_flit();
    do_reset();
    in_data_valid = 1'b1;
    in_data = 32'hA5A5_0001;
    cyc();
    in_data_valid = 1'b0;
    n_total++; if (occupancy !== 3'd1) $display("FAIL single_occ_wr got=%0d exp=1", occupancy); else n_pass++;
    n_total++; if (out_data_valid !== 1'b0) $display("FAIL single_early got=%b exp=0", out_data_valid); else n_pass++;
    cyc();
    n_total++; if (out_data_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_data_valid); else n_pass++;
    n_total++; if (out_data !== 32'hA5A5_0001) $display("FAIL single_data got=%h exp=a5a50001", out_data); else n_pass++;
    n_total++; if (upstream_credit !== 1'b1) $display("FAIL single_ucred got=%b exp=1", upstream_credit); else n_pass++;
    n_total++; if (occupancy !== 3'd0) $display("FAIL single_occ got=%0d exp=0", occupancy); else n_pass++;
    cyc();
    n_total++; if (out_data_valid !== 1'b0) $display("FAIL single_drop got=%b exp=0", out_data_valid); else n_pass++;
    n_total++; if (out_data !== 32'hA5A5_0001) $display("FAIL single_hold got=%h exp=a5a50001", out_data); else n_pass++;
  endtask

  task automatic test_credit_stall();
    logic exp_v;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_data_valid = (i < 6);
      in_data = DW'(i + 1);
      cyc();
      exp_v = (i >= 1) && (i <= 4);
      n_total++; if (out_data_valid !== exp_v) $display("FAIL stall_valid[%0d] got=%b exp=%b", i, out_data_valid, exp_v); else n_pass++;
      if (exp_v) begin
        n_total++; if (out_data !== DW'(i)) $display("FAIL stall_data[%0d] got=%0d exp=%0d", i, out_data, i); else n_pass++;
      end
    end
    n_total++; if (occupancy !== 3'd2) $display("FAIL stall_occ got=%0d exp=2", occupancy); else n_pass++;
    n_total++; if (ucnt !== 4) $display("FAIL stall_ucnt got=%0d exp=4", ucnt); else n_pass++;
    downstream_credit = 1'b1;
    cyc();
    downstream_credit = 1'b0;
    n_total++; if (out_data_valid !== 1'b0) $display("FAIL stall_cr_edge got=%b exp=0", out_data_valid); else n_pass++;
    cyc();
    n_total++; if (out_data_valid !== 1'b1) $display("FAIL stall_f5_valid got=%b exp=1", out_data_valid); else n_pass++;
    n_total++; if (out_data !== 32'd5) $display("FAIL stall_f5_data got=%0d exp=5", out_data); else n_pass++;
    n_total++; if (occupancy !== 3'd1) $display("FAIL stall_f5_occ got=%0d exp=1", occupancy); else n_pass++;
    cyc();
    n_total++; if (out_data_valid !== 1'b0) $display("FAIL stall_f6_held got=%b exp=0", out_data_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_data_valid = 1'b1;
      in_data = DW'(32'hF0 + i);
      cyc();
    end
    in_data_valid = 1'b0;
    cyc(); cyc(); cyc();
    got.delete();
    for (int i = 0; i < 5; i++) begin
      in_data_valid = 1'b1;
      in_data = DW'(11 + i);
      cyc();
    end
    in_data_valid = 1'b0;
    cyc();
    n_total++; if (occupancy !== 3'd4) $display("FAIL ovf_occ got=%0d exp=4", occupancy); else n_pass++;
    n_total++; if (overflow_err !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow_err); else n_pass++;
    n_total++; if (got.size() !== 0) $display("FAIL ovf_leak got=%0d exp=0", got.size()); else n_pass++;
    downstream_credit = 1'b1;
    repeat (4) cyc();
    downstream_credit = 1'b0;
    repeat (3) cyc();
    n_total++; if (got.size() !== 4) $display("FAIL ovf_drain_cnt got=%0d exp=4", got.size()); else n_pass++;
    if (got.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_total++; if (got[i] !== DW'(11 + i)) $display("FAIL ovf_order[%0d] got=%0d exp=%0d", i, got[i], 11 + i); else n_pass++;
      end
    end
    n_total++; if (occupancy !== 3'd0) $display("FAIL ovf_empty got=%0d exp=0", occupancy); else n_pass++;
    n_total++; if (credit_err !== 1'b0) $display("FAIL ovf_cerr got=%b exp=0", credit_err); else n_pass++;
    n_total++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow_err); else n_pass++;
  endtask

  task automatic test_credit_err();
    do_reset();
    downstream_credit = 1'b1;
    cyc();
    downstream_credit = 1'b0;
    n_total++; if (credit_err !== 1'b1) $display("FAIL cerr_flag got=%b exp=1", credit_err); else n_pass++;
    n_total++; if (overflow_err !== 1'b0) $display("FAIL cerr_ovf got=%b exp=0", overflow_err); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      in_data_valid = 1'b1;
      in_data = DW'(32'h40 + i);
      cyc();
    end
    in_data_valid = 1'b0;
    repeat (4) cyc();
    n_total++; if (got.size() !== 4) $display("FAIL cerr_sat_cnt got=%0d exp=4", got.size()); else n_pass++;
    n_total++; if (occupancy !== 3'd2) $display("FAIL cerr_occ got=%0d exp=2", occupancy); else n_pass++;
    n_total++; if (credit_err !== 1'b1) $display("FAIL cerr_sticky got=%b exp=1", credit_err); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int ucnt_before;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_data_valid = 1'b1;
      in_data = DW'(32'h70 + i);
      cyc();
    end
    in_data_valid = 1'b0;
    repeat (3) cyc();
    got.delete();
    for (int i = 0; i < 3; i++) begin
      in_data_valid = 1'b1;
      in_data = DW'(32'h80 + i);
      cyc();
    end
    in_data_valid = 1'b0;
    n_total++; if (occupancy !== 3'd3) $display("FAIL mrst_pre_occ got=%0d exp=3", occupancy); else n_pass++;
    ucnt_before = ucnt;
    rst = 1'b0;
    cyc();
    n_total++; if (occupancy !== 3'd0) $display("FAIL mrst_occ got=%0d exp=0", occupancy); else n_pass++;
    n_total++; if (out_data_valid !== 1'b0) $display("FAIL mrst_valid got=%b exp=0", out_data_valid); else n_pass++;
    n_total++; if (upstream_credit !== 1'b0) $display("FAIL mrst_ucred got=%b exp=0", upstream_credit); else n_pass++;
    rst = 1'b1;
    repeat (3) cyc();
    n_total++; if (ucnt !== ucnt_before) $display("FAIL mrst_ucnt got=%0d exp=%0d", ucnt, ucnt_before); else n_pass++;
    n_total++; if (got.size() !== 0) $display("FAIL mrst_discard got=%0d exp=0", got.size()); else n_pass++;
    in_data_valid = 1'b1;
    in_data = 32'h55;
    cyc();
    in_data_valid = 1'b0;
    repeat (2) cyc();
    n_total++; if (got.size() !== 1) $display("FAIL mrst_post_cnt got=%0d exp=1", got.size()); else n_pass++;
    if (got.size() == 1) begin
      n_total++; if (got[0] !== 32'h55) $display("FAIL mrst_post_data got=%h exp=55", got[0]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      in_data_valid = (i < 20);
      in_data = DW'(i + 1);
      downstream_credit = (i >= 1);
      cyc();
      if (i >= 1) begin
        n_total++; if (out_data_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_data_valid); else n_pass++;
        n_total++; if (out_data !== DW'(i)) $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i, out_data, i); else n_pass++;
      end
    end
    in_data_valid = 1'b0;
    downstream_credit = 1'b0;
    cyc();
    n_total++; if (ucnt !== 20) $display("FAIL b2b_ucnt got=%0d exp=20", ucnt); else n_pass++;
    n_total++; if (occupancy !== 3'd0) $display("FAIL b2b_occ got=%0d exp=0", occupancy); else n_pass++;
    n_total++; if (credit_err !== 1'b0) $display("FAIL b2b_cerr got=%b exp=0", credit_err); else n_pass++;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      in_data_valid = 1'b1;
      in_data = DW'(32'h90 + i);
      cyc();
    end
    in_data_valid = 1'b0;
    repeat (4) cyc();
    n_total++; if (got.size() !== 4) $display("FAIL b2b_counter got=%0d exp=4", got.size()); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    ucnt = 0;
    rst = 1'b0;
    in_data_valid = 1'b0;
    in_data = '0;
    downstream_credit = 1'b0;
    test_reset();
    test_single_flit();
    test_credit_stall();
    test_overflow();
    test_credit_err();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
